// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Loadable up/down counter with a programmable modulus and step.
//               End-of-range modes are wrap, saturate and one-shot. A
//               terminal-count pulse is produced. The optional prescaler is
//               enabled by the COUNTER_PRESCALE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = 255,
    parameter int STEP_W     = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic [STEP_W-1:0]     step,
    input  logic [1:0]            mode,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  halted
);

    // The sum width leaves room for count+step and for a negative count-step.
    localparam int                     SW      = WIDTH + STEP_W + 1;
    localparam logic signed [SW-1:0]   C_MAX_S = SW'(MAX_VAL);
    localparam logic signed [SW-1:0]   C_MOD_S = SW'(MAX_VAL + 1);
    localparam logic signed [SW-1:0]   C_ZERO_S = '0;
    localparam logic [WIDTH-1:0]       C_MAX   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]       C_ZERO  = '0;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [WIDTH-1:0]     count_q, count_d;
    logic                 tc_q, tc_d;
    logic [0:0]           state_q, state_d;

    logic                 w_tick;
    logic                 w_event;
    logic                 w_wrap_mode;
    logic signed [SW-1:0] w_cnt_s;
    logic signed [SW-1:0] w_step_s;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_res;
    logic signed [SW-1:0] w_bound_s;
    logic                 w_over;
    logic                 w_under;
    logic                 w_hit;
    logic                 w_was_at;
    logic [WIDTH-1:0]     w_load_clamped;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    // A tick is due once the prescaler has seen presc enabled cycles; using
    // >= keeps it from running away if presc is lowered mid-count.
    assign w_tick = (presc_q >= presc);

    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (en && (state_q == ST_RUN)) begin
            presc_d = w_tick ? '0 : presc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign w_tick = (PRESCALE_W > 0);
`endif

    assign w_event     = en && (step != '0) && (state_q == ST_RUN) && w_tick;
    assign w_wrap_mode = (mode != MODE_SAT) && (mode != MODE_ONESHOT);

    assign w_cnt_s  = $signed({{(STEP_W + 1){1'b0}}, count_q});
    assign w_step_s = $signed({{(WIDTH + 1){1'b0}}, step});
    assign w_sum    = up ? (w_cnt_s + w_step_s) : (w_cnt_s - w_step_s);
    assign w_over   = (w_sum > C_MAX_S);
    assign w_under  = (w_sum < C_ZERO_S);

    // Step never exceeds MAX_VAL, so one modulus correction is enough to wrap.
    always_comb begin
        w_res = w_sum;
        if (w_wrap_mode) begin
            if (w_over) begin
                w_res = w_sum - C_MOD_S;
            end else if (w_under) begin
                w_res = w_sum + C_MOD_S;
            end
        end else begin
            if (w_over) begin
                w_res = C_MAX_S;
            end else if (w_under) begin
                w_res = C_ZERO_S;
            end
        end
    end

    assign w_bound_s      = up ? C_MAX_S : C_ZERO_S;
    assign w_hit          = (w_res == w_bound_s);
    assign w_was_at       = (count_q == (up ? C_MAX : C_ZERO));
    assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        state_d = state_q;
        if (load) begin
            count_d = w_load_clamped;
            state_d = ST_RUN;
        end else if (w_event) begin
            count_d = w_res[WIDTH-1:0];
            if (w_wrap_mode) begin
                tc_d = w_over || w_under;
            end else begin
                // Parked at the boundary already: no repeat pulse.
                tc_d = w_hit && !w_was_at;
                if ((mode == MODE_ONESHOT) && w_hit) begin
                    state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign halted = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// Bench for param_updown_counter (WIDTH=8, MAX_VAL=9): integer reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_param_updown_counter;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic [3:0] step = '0;
    logic [1:0] mode = '0;
`ifdef COUNTER_PRESCALE_EN
    logic [7:0] presc = '0;
`endif
    logic [7:0] count;
    logic       tc;
    logic       halted;

    int total = 0;
    int bad   = 0;

    param_updown_counter #(
        .WIDTH(8), .MAX_VAL(MAXV), .STEP_W(4), .PRESCALE_W(8)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .en(en), .up(up), .step(step), .mode(mode),
`ifdef COUNTER_PRESCALE_EN
        .presc(presc),
`endif
        .count(count), .tc(tc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the counting rules.
    int m_cnt  = 0;
    int m_pc   = 0;
    bit m_tc   = 1'b0;
    bit m_halt = 1'b0;

    always @(posedge clk or posedge reset) begin : upd
        int s, st, lim, ncnt, npc, pv;
        bit ntc, nhalt, evt;
        if (reset) begin
            m_cnt  <= 0;
            m_pc   <= 0;
            m_tc   <= 1'b0;
            m_halt <= 1'b0;
        end else begin
`ifdef COUNTER_PRESCALE_EN
            pv = presc;
`else
            pv = 0;
`endif
            ncnt  = m_cnt;
            npc   = m_pc;
            ntc   = 1'b0;
            nhalt = m_halt;
            st    = step;
            if (load) begin
                ncnt  = (load_val > MAXV) ? MAXV : load_val;
                nhalt = 1'b0;
                npc   = 0;
            end else if (en && !m_halt) begin
                evt = (m_pc >= pv);
                npc = evt ? 0 : m_pc + 1;
                if (evt && st != 0) begin
                    s = up ? m_cnt + st : m_cnt - st;
                    if (mode == 2'b01 || mode == 2'b10) begin
                        lim  = up ? MAXV : 0;
                        ncnt = (s > MAXV) ? MAXV : ((s < 0) ? 0 : s);
                        ntc  = (ncnt == lim) && (m_cnt != lim);
                        if (mode == 2'b10 && ncnt == lim) nhalt = 1'b1;
                    end else begin
                        ncnt = ((s % (MAXV + 1)) + MAXV + 1) % (MAXV + 1);
                        ntc  = (s > MAXV) || (s < 0);
                    end
                end
            end
            m_cnt  <= ncnt;
            m_pc   <= npc;
            m_tc   <= ntc;
            m_halt <= nhalt;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_count",  32'(count),  32'(m_cnt));
        chk("model_tc",     32'(tc),     32'(m_tc));
        chk("model_halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic lit(input string nm, input logic [7:0] c, input logic t, input logic h);
        chk({nm, "_count"},  32'(count),  32'(c));
        chk({nm, "_tc"},     32'(tc),     32'(t));
        chk({nm, "_halted"}, 32'(halted), 32'(h));
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        #3;
        lit("reset_state", 8'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Wrap, up, step 3 from 8
        mode = 2'b00; up = 1'b1; step = 4'd3; en = 1'b1;
        do_load(8'd8);
        lit("wrap_load", 8'd8, 1'b0, 1'b0);
        tick(); lit("wrap_up1", 8'd1, 1'b1, 1'b0);
        tick(); lit("wrap_up2", 8'd4, 1'b0, 1'b0);
        tick(); lit("wrap_up3", 8'd7, 1'b0, 1'b0);
        tick(); lit("wrap_up4", 8'd0, 1'b1, 1'b0);
        do_load(8'd1);
        up = 1'b0;
        tick(); lit("wrap_dn", 8'd8, 1'b1, 1'b0);

        // Saturate
        mode = 2'b01; up = 1'b1; step = 4'd4;
        do_load(8'd7);
        tick(); lit("sat_up1", 8'd9, 1'b1, 1'b0);
        tick(); lit("sat_up2", 8'd9, 1'b0, 1'b0);
        tick(); lit("sat_up3", 8'd9, 1'b0, 1'b0);
        up = 1'b0;
        do_load(8'd2);
        tick(); lit("sat_dn", 8'd0, 1'b1, 1'b0);
        tick(); lit("sat_dn_park", 8'd0, 1'b0, 1'b0);

        // One-shot down, then mode change while halted, then reload
        mode = 2'b10; up = 1'b0; step = 4'd1;
        do_load(8'd2);
        tick(); lit("os_1", 8'd1, 1'b0, 1'b0);
        tick(); lit("os_0", 8'd0, 1'b1, 1'b1);
        tick(); lit("os_hold", 8'd0, 1'b0, 1'b1);
        mode = 2'b00;
        tick(); lit("os_modechg", 8'd0, 1'b0, 1'b1);
        do_load(8'd5);
        lit("os_reload", 8'd5, 1'b0, 1'b0);
        tick(); lit("os_resume", 8'd4, 1'b0, 1'b0);

        // Load wins over a simultaneous count event, value clamps
        up = 1'b1; step = 4'd3;
        do_load(8'd200);
        lit("load_clamp", 8'd9, 1'b0, 1'b0);
        step = 4'd0;
        tick(); lit("step0_hold", 8'd9, 1'b0, 1'b0);
        step = 4'd1; en = 1'b0;
        tick(); lit("en0_hold", 8'd9, 1'b0, 1'b0);

        // Asynchronous reset mid-count
        en = 1'b1;
        do_load(8'd5);
        #2 reset = 1'b1;
        #1 lit("async_rst_mid", 8'd0, 1'b0, 1'b0);
        compare_model();
        #1 reset = 1'b0;

        // Asynchronous reset while halted
        mode = 2'b10; up = 1'b1; step = 4'd1;
        do_load(8'd8);
        tick(); lit("os_up_halt", 8'd9, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 lit("async_rst_halt", 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        tick(); lit("after_rst_run", 8'd1, 1'b0, 1'b0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaler: 6 enabled cycles at presc=2 give two events
        presc = 8'd2; mode = 2'b00; up = 1'b1; step = 4'd1; en = 1'b0;
        do_load(8'd0);
        en = 1'b1; tick(); tick();
        en = 1'b0; tick(); tick(); tick();
        lit("presc_gap", 8'd0, 1'b0, 1'b0);
        en = 1'b1; tick();
        lit("presc_ev1", 8'd1, 1'b0, 1'b0);
        tick(); tick(); tick();
        lit("presc_ev2", 8'd2, 1'b0, 1'b0);
        presc = 8'd0;
`endif

        // Mixed sweep against the model
        for (int i = 0; i < 200; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            step     = 4'($urandom_range(0, MAXV));
            mode     = 2'($urandom_range(0, 3));
`ifdef COUNTER_PRESCALE_EN
            presc    = 8'($urandom_range(0, 2));
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
